ram_sdp_clr: RTL and testbench
==============================

// Module: ram_sdp_clr
// PURPOSE
//   Parametrised simple-dual-port RAM: one write port, one read port, one clock.
//   Successor to the fixed 16x256 single-port ram. Adds byte enables and a selectable read latency.
//   Adds read-during-write mode selection and a hardware clear engine that sweeps memory to INIT_VAL.
//   Used as scratch/buffer storage wherever a cleared, width/depth-tunable RAM is needed.
// PARAMETERS
//   DATA_W     16          data width; must be a multiple of 8
//   ADDR_W     8           address width
//   DEPTH      1<<ADDR_W   number of words; DEPTH <= 2**ADDR_W
//   RD_LAT     1           read latency in cycles; legal values 1 or 2
//   RDW_MODE   0           same-address read/write: 0 = old data, 1 = new data (write-through)
//   INIT_VAL   '0          word written to every location by the clear engine
// PORTS
//   clk       in   1         clock; all activity on rising edge
//   rst       in   1         asynchronous, active-high reset
//   clear     in   1         1-cycle request to re-sweep memory to INIT_VAL
//   busy      out  1         1 while clear engine runs; all user accesses ignored
//   wr_en     in   1         write strobe
//   wr_addr   in   ADDR_W    write address
//   wr_data   in   DATA_W    write data
//   wr_be     in   DATA_W/8  byte enables; bit i gates wr_data[8i+7:8i]
//   rd_en     in   1         read strobe
//   rd_addr   in   ADDR_W    read address
//   rd_data   out  DATA_W    read data; holds last value when rd_valid=0
//   rd_valid  out  1         1-cycle pulse qualifying rd_data
// BEHAVIOUR
//   Reset (async, immediate): rd_data=0, rd_valid=0, read pipe flushed.
//     Reset also sets busy=1, state=CLEAR, sweep counter=0. Memory contents are not touched by reset itself.
//   FSM states: CLEAR, READY.
//     CLEAR: writes INIT_VAL to address cnt each cycle (all bytes), cnt++.
//       After address DEPTH-1 the FSM goes to READY; busy drops on that same edge.
//       A full sweep takes exactly DEPTH cycles after rst deasserts.
//     READY: user ports live. clear=1 -> CLEAR next edge, cnt=0, busy=1.
//       Same-cycle wr_en/rd_en are still performed.
//   While busy: wr_en, rd_en and clear are ignored; no new rd_valid is produced.
//     Reads accepted before busy rose still complete normally.
//   rst asserted mid-sweep: sweep restarts at address 0 after release.
//   Write: wr_en=1 updates only the bytes with wr_be set, at the edge; wr_be=0 is a no-op.
//   Read: rd_en at edge N -> rd_data/rd_valid at edge N+RD_LAT. Back-to-back reads give 1 result per cycle.
//   Read-during-write, same address, same edge:
//     RDW_MODE=0 returns the pre-write word.
//     RDW_MODE=1 returns the merged word, using only the bytes with wr_be set from the new data.
//   Address >= DEPTH: write dropped; read returns 0 with rd_valid=1.
//   RD_LAT=2 adds one output register stage after the array read.
// STRUCTURE
//   ram_pkg: state_e {CLEAR, READY}; constants RDW_OLD=0, RDW_NEW=1.
//   ram_pkg: function be_merge(old, new, be) returning the byte-merged word.
//   Sub-module ram_rd_pipe (DATA_W, RD_LAT): valid/data delay line with async reset.
//   Top holds the array, sweep FSM/counter, write merge and collision mux.
// TESTING
//   1 Reset then idle: busy=1 for exactly 256 cycles (DEPTH=256).
//     Then read all addresses -> every rd_data=0 with rd_valid.
//   2 Write addr i data i*2 for i=0..255 (wr_be=2'b11), then read back.
//     Expect rd_data=i*2 exactly RD_LAT cycles after rd_en. Run with RD_LAT=1 and with RD_LAT=2.
//   3 Byte enables: write 16'hAAAA to addr 5, then 16'h1234 with wr_be=2'b01.
//     Read -> 16'hAA34. Then write with wr_be=2'b00 -> still 16'hAA34.
//   4 Collision: addr 7 holds 16'h0001. Same edge: write 16'hBEEF to addr 7 and read addr 7.
//     RDW_MODE=0 -> 16'h0001; RDW_MODE=1 -> 16'hBEEF.
//   5 Pulse clear in READY with INIT_VAL=16'h5A5A: busy=1 for 256 cycles.
//     wr_en/rd_en during that window are ignored (no rd_valid). Afterwards all reads return 16'h5A5A.
//   6 Assert rst at sweep cycle 100: outputs are 0 immediately.
//     After release busy lasts a full 256 cycles. DEPTH=200 variant: read addr 220 -> 0, write to 220 dropped.

Source files
------------

// File: rtl/ram_sdp_clr_pkg.sv
// Shared types and helpers for the ram_sdp_clr simple-dual-port RAM.
package ram_sdp_clr_pkg;

  typedef enum logic [0:0] {
    StClear,
    StReady
  } state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  // Widest word be_merge handles; callers zero-extend and truncate around it.
  localparam int unsigned MaxDataW = 1024;
  localparam int unsigned MaxBeW   = MaxDataW / 8;

  function automatic logic [MaxDataW-1:0] be_merge(input logic [MaxDataW-1:0] old_word,
                                                   input logic [MaxDataW-1:0] new_word,
                                                   input logic [MaxBeW-1:0]   be);
    logic [MaxDataW-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MaxBeW); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_sdp_clr_rd_pipe.sv
// Read-result delay line: RD_LAT register stages of valid/data; data holds when not valid.
module ram_sdp_clr_rd_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [DATA_W-1:0] dat_q [RD_LAT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= valid_i;
      if (valid_i) dat_q[0] <= data_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[RD_LAT-1];
  assign data_o  = dat_q[RD_LAT-1];

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple-dual-port RAM with byte enables, selectable read latency, read-during-write mode
// and a clear engine that sweeps every word to INIT_VAL after reset or on request.
module ram_sdp_clr
  import ram_sdp_clr_pkg::*;
#(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DEPTH    = 1 << ADDR_W,
  parameter int unsigned       RD_LAT   = 1,
  parameter int unsigned       RDW_MODE = RDW_OLD,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  output logic                busy_o,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  input  logic                rd_en_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o
);

  localparam int unsigned     AddrW1   = ADDR_W + 1;
  localparam logic [ADDR_W:0] DepthLim = AddrW1'(DEPTH);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e              state_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                ready;
  logic                wr_fire;
  logic                rd_fire;
  logic                rd_in_range;
  logic [DATA_W-1:0]   merged_word;
  logic [DATA_W-1:0]   rd_word;

  assign ready       = (state_q == StReady);
  assign wr_fire     = ready & wr_en_i & ({1'b0, wr_addr_i} < DepthLim);
  assign rd_fire     = ready & rd_en_i;
  assign rd_in_range = ({1'b0, rd_addr_i} < DepthLim);

  assign merged_word = DATA_W'(be_merge(MaxDataW'(mem_q[wr_addr_i]), MaxDataW'(wr_data_i),
                                        MaxBeW'(wr_be_i)));

  // Out-of-range reads still complete, returning zero.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rd_addr_i];
      if (RDW_MODE == RDW_NEW && wr_fire && wr_addr_i == rd_addr_i) rd_word = merged_word;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StClear;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StClear: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastAddr) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StReady: begin
          if (clear_i) begin
            state_q <= StClear;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StClear;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // While rst is held this rewrites INIT_VAL at address 0, which the sweep writes first anyway.
  always_ff @(posedge clk_i) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= INIT_VAL;
    end else if (wr_fire) begin
      mem_q[wr_addr_i] <= merged_word;
    end
  end

  assign busy_o = busy_q;

  ram_sdp_clr_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (rd_fire),
    .data_i  (rd_word),
    .valid_o (rd_valid_o),
    .data_o  (rd_data_o)
  );

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: three configurations share one stimulus stream, each checked
// every cycle against a behavioural memory model plus hand-computed spot values.
module tb_ram_sdp_clr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  rd_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;

  logic        busy     [3];
  logic        rd_valid [3];
  logic [15:0] rd_data  [3];

  // Instance configs: a = lat1/old/init0, b = lat2/new/init 5A5A, c = depth 200.
  int          depth_p [3] = '{256, 256, 200};
  int          lat_p   [3] = '{1, 2, 1};
  int          mode_p  [3] = '{0, 1, 0};
  logic [15:0] init_p  [3] = '{16'h0000, 16'h5A5A, 16'h0000};

  int   passed = 0;
  int   total  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(1), .RDW_MODE(0),
                .INIT_VAL(16'h0000)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[0]),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0])
  );

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .RD_LAT(2), .RDW_MODE(1),
                .INIT_VAL(16'h5A5A)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[1]),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1])
  );

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .RD_LAT(1), .RDW_MODE(0),
                .INIT_VAL(16'h0000)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .busy_o(busy[2]),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_be_i(wr_be),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2])
  );

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s dut%0d: got %h, expected %h", name, idx, act, exp);
    else passed++;
  endtask

  // Model: memory image, sweep cycles left, and results scheduled k edges ahead.
  logic [15:0] mm    [3][256];
  int          bl    [3];
  logic        sv    [3][3];
  logic [15:0] sd    [3][3];
  logic        exp_v [3];
  logic [15:0] exp_d [3];
  logic        m_busy, m_wr_ok;
  logic [15:0] m_rv;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      bl[i] = depth_p[i];
      exp_v[i] = 1'b0;
      exp_d[i] = 16'h0;
      for (int k = 0; k < 3; k++) begin
        sv[i][k] = 1'b0;
        sd[i][k] = 16'h0;
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      m_busy  = bl[i] > 0;
      m_wr_ok = !m_busy && wr_en && (int'(wr_addr) < depth_p[i]);
      m_rv    = (int'(rd_addr) < depth_p[i]) ? mm[i][rd_addr] : 16'h0;
      if (mode_p[i] == 1 && m_wr_ok && wr_addr == rd_addr)
        for (int b = 0; b < 2; b++) if (wr_be[b]) m_rv[8*b +: 8] = wr_data[8*b +: 8];
      for (int k = 0; k < 2; k++) begin
        sv[i][k] = sv[i][k+1];
        sd[i][k] = sd[i][k+1];
      end
      sv[i][2] = 1'b0;
      if (!m_busy && rd_en) begin
        sv[i][lat_p[i]-1] = 1'b1;
        sd[i][lat_p[i]-1] = m_rv;
      end
      exp_v[i] = sv[i][0];
      if (sv[i][0]) exp_d[i] = sd[i][0];
      if (m_wr_ok)
        for (int b = 0; b < 2; b++) if (wr_be[b]) mm[i][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      if (m_busy) begin
        mm[i][depth_p[i] - bl[i]] = init_p[i];
        bl[i]--;
      end else if (clear) begin
        bl[i] = depth_p[i];
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check("busy", i, 32'(busy[i]), 32'(bl[i] > 0));
        check("rd_valid", i, 32'(rd_valid[i]), 32'(exp_v[i]));
        check("rd_data", i, 32'(rd_data[i]), 32'(exp_d[i]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
    step();
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rd(input logic [7:0] a);
    step();
    rd_en = 1'b1; rd_addr = a;
  endtask

  task automatic rd_all();
    for (int a = 0; a < 256; a++) rd(8'(a));
    idle(4);
  endtask

  // Releases rst on a negedge, then counts the cycles each instance stays busy.
  task automatic release_and_measure();
    int c [3];
    c = '{0, 0, 0};
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      #1;
      for (int i = 0; i < 3; i++) c[i] += int'(busy[i]);
      @(negedge clk);
    end
    check("busy_len", 0, c[0], 256);
    check("busy_len", 1, c[1], 256);
    check("busy_len", 2, c[2], 200);
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    step();
    release_and_measure();

    // Fresh sweep contents.
    rd_all();
    check("init_rd", 0, 32'(rd_data[0]), 32'h0000);
    check("init_rd", 1, 32'(rd_data[1]), 32'h5A5A);

    // Full write then read back.
    for (int a = 0; a < 256; a++) wr(8'(a), 16'(a * 2), 2'b11);
    rd_all();
    check("wr_rd_last", 0, 32'(rd_data[0]), 32'h01FE);
    check("wr_rd_last", 1, 32'(rd_data[1]), 32'h01FE);
    check("wr_rd_last", 2, 32'(rd_data[2]), 32'h0000);

    // Byte enables.
    wr(8'd5, 16'hAAAA, 2'b11);
    wr(8'd5, 16'h1234, 2'b01);
    rd(8'd5);
    idle(4);
    check("be_lo", 0, 32'(rd_data[0]), 32'hAA34);
    check("be_lo", 1, 32'(rd_data[1]), 32'hAA34);
    wr(8'd5, 16'hFFFF, 2'b00);
    rd(8'd5);
    idle(4);
    check("be_none", 0, 32'(rd_data[0]), 32'hAA34);
    check("be_none", 2, 32'(rd_data[2]), 32'hAA34);

    // Same-address read during write.
    wr(8'd7, 16'h0001, 2'b11);
    step();
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 16'hBEEF; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 8'd7;
    idle(4);
    check("rdw_old", 0, 32'(rd_data[0]), 32'h0001);
    check("rdw_new", 1, 32'(rd_data[1]), 32'hBEEF);
    check("rdw_old", 2, 32'(rd_data[2]), 32'h0001);
    rd(8'd7);
    idle(4);
    check("rdw_after", 0, 32'(rd_data[0]), 32'hBEEF);

    // Clear request with user traffic during the sweep.
    step();
    clear = 1'b1;
    for (int k = 0; k < 256; k++) begin
      step();
      wr_en = 1'b1; wr_addr = 8'(k); wr_data = 16'hDEAD; wr_be = 2'b11;
      rd_en = 1'b1; rd_addr = 8'(k);
    end
    idle(4);
    rd_all();
    check("clear_rd", 0, 32'(rd_data[0]), 32'h0000);
    check("clear_rd", 1, 32'(rd_data[1]), 32'h5A5A);

    // Reset in the middle of a sweep.
    wr(8'd9, 16'h1357, 2'b11);
    rd(8'd9);
    idle(4);
    check("pre_rst", 0, 32'(rd_data[0]), 32'h1357);
    step();
    clear = 1'b1;
    idle(100);
    rst = 1'b1;
    #1;
    check("rst_rd_data", 0, 32'(rd_data[0]), 32'h0000);
    check("rst_rd_data", 2, 32'(rd_data[2]), 32'h0000);
    check("rst_busy", 0, 32'(busy[0]), 32'h1);
    idle(2);
    release_and_measure();

    // Addresses beyond DEPTH on the 200-word instance.
    wr(8'd20, 16'h7777, 2'b11);
    rd(8'd20);
    idle(4);
    check("in_range", 2, 32'(rd_data[2]), 32'h7777);
    wr(8'd220, 16'h4321, 2'b11);
    rd(8'd220);
    idle(4);
    check("oor_rd", 2, 32'(rd_data[2]), 32'h0000);
    check("oor_ref", 0, 32'(rd_data[0]), 32'h4321);

    idle(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
